// File: rtl/softmax_n.sv
`default_nettype none
// ============================================================================
// softmax_n : streaming N-class float32 softmax with arg-max report.
// Optional max-subtraction is enabled by defining SOFTMAX_MAXSUB_EN.  Rev 1.0
// ============================================================================
module softmax_n #(
   parameter int N_CLASS = 10,
   parameter int IDX_W   = $clog2(N_CLASS)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [IDX_W-1:0] out_index,
   output logic             out_last,
   output logic [IDX_W-1:0] argmax,
   output logic             argmax_valid,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_EXP   = 2'd1,
      S_RECIP = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_CLASS - 1);

   // Exponent field 0 flushes to signed zero; Inf/NaN keep their all-ones exponent.
   function automatic real f32_to_real(input logic [31:0] f);
      logic [10:0] e;
      if (f[30:23] == 8'd0) return $bitstoreal({f[31], 63'd0});
      if (f[30:23] == 8'hFF) e = 11'h7FF;
      else                   e = {3'b000, f[30:23]} + 11'd896;
      return $bitstoreal({f[31], e, f[22:0], 29'd0});
   endfunction

   function automatic logic [31:0] real_to_f32(input real r);
      logic [63:0] b;
      logic [10:0] e;
      logic [28:0] unused_lsb;
      b          = $realtobits(r);
      e          = b[62:52];
      unused_lsb = b[28:0];
      if (e == 11'h7FF) return 32'h7FC0_0000;
      if (e < 11'd897)  return 32'd0;
      if (e > 11'd1150) return {b[63], 8'hFF, 23'd0};
      return {b[63], e[7:0] - 8'd128, b[51:29]};
   endfunction

   state_t           r_state;
   state_t           w_state_next;
   logic [IDX_W-1:0] r_cnt;
   real              r_buf [N_CLASS];
   real              r_sum;
   real              r_inv;
   real              r_max;
   logic [IDX_W-1:0] r_max_idx;
   logic [IDX_W-1:0] r_argmax;
   logic             r_argmax_valid;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_out_last;
   logic [31:0]      r_out_data;
   logic [IDX_W-1:0] r_out_index;

   logic             w_in_hs;
   logic             w_out_hs;
   logic             w_cnt_last;
   logic             w_new_max;
   logic [IDX_W-1:0] w_next_idx;
   real              w_in_real;
   real              w_exp;

   assign w_in_hs    = in_valid & r_in_ready;
   assign w_out_hs   = r_out_valid & out_ready;
   assign w_cnt_last = (r_cnt == c_last_idx);
   assign w_next_idx = r_cnt + 1'b1;

   always_comb begin
      w_in_real = f32_to_real(in_data);
      // First beat of a vector always seeds the tracker; strict compare keeps the lowest tied index.
      w_new_max = (r_cnt == '0) || (w_in_real > r_max);
`ifdef SOFTMAX_MAXSUB_EN
      w_exp     = $exp(r_buf[r_cnt] - r_max);
`else
      w_exp     = $exp(r_buf[r_cnt]);
`endif
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_LOAD;
      else         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_LOAD:  if (w_in_hs && w_cnt_last)             w_state_next = S_EXP;
         S_EXP:   if (w_cnt_last)                        w_state_next = S_RECIP;
         S_RECIP:                                        w_state_next = S_OUT;
         S_OUT:   if (w_out_hs && r_out_last)            w_state_next = S_LOAD;
         default:                                        w_state_next = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt          <= '0;
         r_sum          <= 0.0;
         r_inv          <= 0.0;
         r_max          <= 0.0;
         r_max_idx      <= '0;
         r_argmax       <= '0;
         r_argmax_valid <= 1'b0;
         r_in_ready     <= 1'b0;
         r_out_valid    <= 1'b0;
         r_out_last     <= 1'b0;
         r_out_data     <= 32'd0;
         r_out_index    <= '0;
         for (int i = 0; i < N_CLASS; i++) r_buf[i] <= 0.0;
      end else begin
         r_in_ready <= (w_state_next == S_LOAD);
         case (r_state)
            S_LOAD: begin
               if (w_in_hs) begin
                  r_buf[r_cnt] <= w_in_real;
                  if (w_new_max) begin
                     r_max     <= w_in_real;
                     r_max_idx <= r_cnt;
                  end
                  if (r_cnt == '0) r_argmax_valid <= 1'b0;
                  if (w_cnt_last) begin
                     r_cnt          <= '0;
                     r_argmax       <= w_new_max ? r_cnt : r_max_idx;
                     r_argmax_valid <= 1'b1;
                  end else begin
                     r_cnt <= w_next_idx;
                  end
               end
            end
            S_EXP: begin
               r_buf[r_cnt] <= w_exp;
               r_sum        <= r_sum + w_exp;
               r_cnt        <= w_cnt_last ? '0 : w_next_idx;
            end
            S_RECIP: r_inv <= 1.0 / r_sum;
            S_OUT: begin
               // The first OUT cycle only loads beat 0, giving the registered output stage.
               if (!r_out_valid) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= real_to_f32(r_buf[r_cnt] * r_inv);
                  r_out_index <= r_cnt;
                  r_out_last  <= w_cnt_last;
               end else if (out_ready) begin
                  if (r_out_last) begin
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     r_cnt       <= '0;
                     r_sum       <= 0.0;
                     r_max       <= 0.0;
                     r_max_idx   <= '0;
                  end else begin
                     r_cnt       <= w_next_idx;
                     r_out_data  <= real_to_f32(r_buf[w_next_idx] * r_inv);
                     r_out_index <= w_next_idx;
                     r_out_last  <= (w_next_idx == c_last_idx);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready     = r_in_ready;
   assign out_valid    = r_out_valid;
   assign out_data     = r_out_data;
   assign out_index    = r_out_index;
   assign out_last     = r_out_last;
   assign argmax       = r_argmax;
   assign argmax_valid = r_argmax_valid;
   assign busy         = !((r_state == S_LOAD) && (r_cnt == '0));

endmodule
`default_nettype wire
